// File: rtl/alu_pipe_if.sv
// Issue/result bundle between the issue stage and alu_pipe.
// The master drives operations and consumes results; the slave is the ALU.
interface alu_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [4:0]       opcode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             negative;
    logic             carry_out;
    logic             overflow;
    logic             illegal_op;
    logic             busy;

    modport master (
        output in_valid, a, b, opcode, out_ready,
        input  in_ready, out_valid, result, zero, negative,
               carry_out, overflow, illegal_op, busy
    );

    modport slave (
        input  in_valid, a, b, opcode, out_ready,
        output in_ready, out_valid, result, zero, negative,
               carry_out, overflow, illegal_op, busy
    );
endinterface

// File: rtl/alu_pipe.sv
// Registered ALU: single-cycle ops land one cycle after the handshake; unsigned
// multiply (shift-add) and divide (restoring) iterate once per bit in CALC.
// The result register holds its contents until the consumer takes them.
module alu_pipe #(
    parameter int WIDTH = 32
) (
    input logic     clk,
    input logic     rst_n,
    alu_pipe_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH) + 1;

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_AND   = 5'd2;
    localparam logic [4:0] OP_OR    = 5'd3;
    localparam logic [4:0] OP_XOR   = 5'd4;
    localparam logic [4:0] OP_NOR   = 5'd5;
    localparam logic [4:0] OP_SLL   = 5'd6;
    localparam logic [4:0] OP_SRL   = 5'd7;
    localparam logic [4:0] OP_SRA   = 5'd8;
    localparam logic [4:0] OP_SLT   = 5'd9;
    localparam logic [4:0] OP_SLTU  = 5'd10;
    localparam logic [4:0] OP_EQ    = 5'd11;
    localparam logic [4:0] OP_NEQ   = 5'd12;
    localparam logic [4:0] OP_GT    = 5'd13;
    localparam logic [4:0] OP_LT    = 5'd14;
    localparam logic [4:0] OP_PASS  = 5'd15;
    localparam logic [4:0] OP_MUL   = 5'd16;
    localparam logic [4:0] OP_MULHU = 5'd17;
    localparam logic [4:0] OP_DIVU  = 5'd18;
    localparam logic [4:0] OP_REMU  = 5'd19;

    typedef enum logic {IDLE, CALC} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       mop_q, mop_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             ill_q, ill_d;
    logic             outValid_q, outValid_d;

    logic             inReady;
    logic             accept;
    logic             isMulti;
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   addSum;
    logic [WIDTH:0]   subDiff;
    logic [WIDTH-1:0] aluRes;
    logic             aluCarry;
    logic             aluOvf;
    logic             aluIll;
    logic [WIDTH:0]   mulSum;
    logic [WIDTH:0]   remShift;
    logic [WIDTH-1:0] stepHi;
    logic [WIDTH-1:0] stepLo;
    logic             wr;
    logic [WIDTH-1:0] wrRes;
    logic             wrCarry;
    logic             wrOvf;
    logic             wrIll;

    assign inReady = rst_n && (state_q == IDLE) && (!outValid_q || bus.out_ready);
    assign accept  = bus.in_valid && inReady;
    assign isMulti = (bus.opcode[4:2] == 3'b100);
    assign shamt   = bus.b[SHW-1:0];
    assign addSum  = {1'b0, bus.a} + {1'b0, bus.b};
    assign subDiff = {1'b0, bus.a} - {1'b0, bus.b};

    // Single-cycle datapath evaluated straight from the offered operands.
    always_comb begin
        aluRes   = '0;
        aluCarry = 1'b0;
        aluOvf   = 1'b0;
        aluIll   = 1'b0;
        case (bus.opcode)
            OP_ADD: begin
                aluRes   = addSum[WIDTH-1:0];
                aluCarry = addSum[WIDTH];
                aluOvf   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (addSum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                aluRes   = subDiff[WIDTH-1:0];
                aluCarry = subDiff[WIDTH];
                aluOvf   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (subDiff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND:  aluRes = bus.a & bus.b;
            OP_OR:   aluRes = bus.a | bus.b;
            OP_XOR:  aluRes = bus.a ^ bus.b;
            OP_NOR:  aluRes = ~(bus.a | bus.b);
            OP_SLL:  aluRes = bus.a << shamt;
            OP_SRL:  aluRes = bus.a >> shamt;
            OP_SRA:  aluRes = WIDTH'($signed(bus.a) >>> shamt);
            OP_SLT:  aluRes = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_SLTU: aluRes = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            OP_EQ:   aluRes = {{(WIDTH-1){1'b0}}, (bus.a == bus.b)};
            OP_NEQ:  aluRes = {{(WIDTH-1){1'b0}}, (bus.a != bus.b)};
            OP_GT:   aluRes = {{(WIDTH-1){1'b0}}, ($signed(bus.a) > $signed(bus.b))};
            OP_LT:   aluRes = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_PASS: aluRes = bus.a;
            OP_MUL, OP_MULHU, OP_DIVU, OP_REMU: aluRes = '0;
            default: aluIll = 1'b1;
        endcase
    end

    // One multiply or divide iteration; hi holds partial product / remainder,
    // lo holds the multiplier / dividend being shifted into the quotient.
    always_comb begin
        mulSum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        remShift = {hi_q, lo_q[WIDTH-1]};
        stepHi   = mulSum[WIDTH:1];
        stepLo   = {mulSum[0], lo_q[WIDTH-1:1]};
        if (mop_q[1]) begin
            if (remShift >= {1'b0, opnd_q}) begin
                stepHi = remShift[WIDTH-1:0] - opnd_q;
                stepLo = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                stepHi = remShift[WIDTH-1:0];
                stepLo = {lo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Next-state logic for the FSM, iteration registers and output register.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mop_d      = mop_q;
        opnd_d     = opnd_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        result_d   = result_q;
        zero_d     = zero_q;
        neg_d      = neg_q;
        carry_d    = carry_q;
        ovf_d      = ovf_q;
        ill_d      = ill_q;
        outValid_d = outValid_q && !bus.out_ready;
        wr         = 1'b0;
        wrRes      = '0;
        wrCarry    = 1'b0;
        wrOvf      = 1'b0;
        wrIll      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (isMulti) begin
                        state_d = CALC;
                        cnt_d   = CW'(WIDTH);
                        mop_d   = bus.opcode[1:0];
                        hi_d    = '0;
                        if (bus.opcode[1]) begin
                            lo_d   = bus.a;
                            opnd_d = bus.b;
                        end else begin
                            lo_d   = bus.b;
                            opnd_d = bus.a;
                        end
                    end else begin
                        wr      = 1'b1;
                        wrRes   = aluRes;
                        wrCarry = aluCarry;
                        wrOvf   = aluOvf;
                        wrIll   = aluIll;
                    end
                end
            end
            CALC: begin
                hi_d  = stepHi;
                lo_d  = stepLo;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    wr      = 1'b1;
                    case (mop_q)
                        2'b00: begin wrRes = stepLo; wrCarry = (stepHi != '0); end
                        2'b01: begin wrRes = stepHi; wrCarry = (stepHi != '0); end
                        2'b10: begin wrRes = stepLo; wrOvf = (opnd_q == '0); end
                        default: begin wrRes = stepHi; wrOvf = (opnd_q == '0); end
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
        if (wr) begin
            result_d   = wrRes;
            zero_d     = (wrRes == '0);
            neg_d      = wrRes[WIDTH-1];
            carry_d    = wrCarry;
            ovf_d      = wrOvf;
            ill_d      = wrIll;
            outValid_d = 1'b1;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mop_q      <= '0;
            opnd_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            neg_q      <= 1'b0;
            carry_q    <= 1'b0;
            ovf_q      <= 1'b0;
            ill_q      <= 1'b0;
            outValid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mop_q      <= mop_d;
            opnd_q     <= opnd_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            neg_q      <= neg_d;
            carry_q    <= carry_d;
            ovf_q      <= ovf_d;
            ill_q      <= ill_d;
            outValid_q <= outValid_d;
        end
    end

    assign bus.in_ready   = inReady;
    assign bus.out_valid  = outValid_q;
    assign bus.result     = result_q;
    assign bus.zero       = zero_q;
    assign bus.negative   = neg_q;
    assign bus.carry_out  = carry_q;
    assign bus.overflow   = ovf_q;
    assign bus.illegal_op = ill_q;
    assign bus.busy       = (state_q == CALC);
endmodule

// File: tb/tb_alu_pipe.sv
// Directed testbench for alu_pipe: 32-bit instance for all features plus an
// 8-bit instance for the narrow multiply case.
module tb_alu_pipe;
    logic clk = 1'b0;
    logic rst_n;
    int   nCompared = 0;
    int   nFailed   = 0;

    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(32)) bus32 ();
    alu_pipe_if #(.WIDTH(8))  bus8 ();

    alu_pipe #(.WIDTH(32)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus32));
    alu_pipe #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

    // Offer one operation on the 32-bit bus.
    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        bus32.in_valid = 1'b1;
        bus32.opcode   = op;
        bus32.a        = a;
        bus32.b        = b;
    endtask

    // Issue a multi-cycle op, scramble the inputs, and count edges until out_valid.
    task automatic run_multi(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                             output int cycles, output bit busyOk);
        @(negedge clk);
        drive(op, a, b);
        @(negedge clk);
        bus32.in_valid = 1'b0;
        bus32.a        = 32'hDEADBEEF;
        bus32.b        = 32'h0BADF00D;
        cycles = 0;
        busyOk = 1'b1;
        while (bus32.out_valid !== 1'b1 && cycles < 100) begin
            if (!(bus32.busy === 1'b1 && bus32.in_ready === 1'b0)) busyOk = 1'b0;
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        nCompared++; if (bus32.in_ready !== 1'b0) begin nFailed++; $display("[TB] FAIL reset_in_ready: got %b expected 0", bus32.in_ready); end
        nCompared++; if (bus32.out_valid !== 1'b0) begin nFailed++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus32.out_valid); end
        nCompared++; if (bus32.result !== 32'h0) begin nFailed++; $display("[TB] FAIL reset_result: got %h expected 0", bus32.result); end
        nCompared++; if ({bus32.zero, bus32.negative, bus32.carry_out, bus32.overflow, bus32.illegal_op, bus32.busy} !== 6'b0)
            begin nFailed++; $display("[TB] FAIL reset_flags: got %b expected 000000", {bus32.zero, bus32.negative, bus32.carry_out, bus32.overflow, bus32.illegal_op, bus32.busy}); end
        nCompared++; if (bus8.out_valid !== 1'b0) begin nFailed++; $display("[TB] FAIL reset8_out_valid: got %b expected 0", bus8.out_valid); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add_sub();
        drive(5'd0, 32'h7FFFFFFF, 32'h1);
        #1;
        nCompared++; if (bus32.in_ready !== 1'b1) begin nFailed++; $display("[TB] FAIL add_in_ready: got %b expected 1", bus32.in_ready); end
        @(negedge clk);
        bus32.in_valid = 1'b0;
        nCompared++; if (bus32.out_valid !== 1'b1) begin nFailed++; $display("[TB] FAIL add_out_valid: got %b expected 1", bus32.out_valid); end
        nCompared++; if (bus32.result !== 32'h80000000) begin nFailed++; $display("[TB] FAIL add_result: got %h expected 80000000", bus32.result); end
        nCompared++; if ({bus32.overflow, bus32.negative, bus32.carry_out, bus32.zero} !== 4'b1100)
            begin nFailed++; $display("[TB] FAIL add_flags(ovf,neg,c,z): got %b expected 1100", {bus32.overflow, bus32.negative, bus32.carry_out, bus32.zero}); end
        drive(5'd1, 32'h0, 32'h1);
        @(negedge clk);
        bus32.in_valid = 1'b0;
        nCompared++; if (bus32.result !== 32'hFFFFFFFF) begin nFailed++; $display("[TB] FAIL sub_result: got %h expected ffffffff", bus32.result); end
        nCompared++; if ({bus32.carry_out, bus32.overflow} !== 2'b10)
            begin nFailed++; $display("[TB] FAIL sub_flags(c,ovf): got %b expected 10", {bus32.carry_out, bus32.overflow}); end
    endtask

    task automatic test_shift_cmp();
        logic [4:0]  ops  [10];
        logic [31:0] as   [10];
        logic [31:0] bs   [10];
        logic [31:0] exps [10];
        ops  = '{5'd6, 5'd7, 5'd5, 5'd13, 5'd14, 5'd11, 5'd12, 5'd9, 5'd4, 5'd3};
        as   = '{32'h1, 32'h80000000, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h5, 32'h5, 32'h1, 32'hF0F0, 32'h0F0};
        bs   = '{32'h23, 32'd31, 32'h0, 32'h1, 32'h1, 32'h5, 32'h5, 32'hFFFFFFFF, 32'h0FF0, 32'hF00};
        exps = '{32'h8, 32'h1, 32'hFFFFFFFF, 32'h0, 32'h1, 32'h1, 32'h0, 32'h0, 32'hFF00, 32'hFF0};
        for (int i = 0; i < 10; i++) begin
            drive(ops[i], as[i], bs[i]);
            @(negedge clk);
            bus32.in_valid = 1'b0;
            nCompared++; if (bus32.result !== exps[i])
                begin nFailed++; $display("[TB] FAIL vec%0d_op%0d: got %h expected %h", i, ops[i], bus32.result, exps[i]); end
        end
    endtask

    task automatic test_back_to_back();
        bit readyOk = 1'b1;
        drive(5'd2, 32'hF0F0F0F0, 32'hFF00FF00);
        #1; if (bus32.in_ready !== 1'b1) readyOk = 1'b0;
        @(negedge clk);
        nCompared++; if (bus32.result !== 32'hF000F000) begin nFailed++; $display("[TB] FAIL b2b_and: got %h expected f000f000", bus32.result); end
        drive(5'd8, 32'h80000000, 32'h4);
        #1; if (bus32.in_ready !== 1'b1) readyOk = 1'b0;
        @(negedge clk);
        nCompared++; if (bus32.result !== 32'hF8000000) begin nFailed++; $display("[TB] FAIL b2b_sra: got %h expected f8000000", bus32.result); end
        drive(5'd10, 32'h1, 32'hFFFFFFFF);
        #1; if (bus32.in_ready !== 1'b1) readyOk = 1'b0;
        @(negedge clk);
        bus32.in_valid = 1'b0;
        nCompared++; if (bus32.result !== 32'h1) begin nFailed++; $display("[TB] FAIL b2b_sltu: got %h expected 1", bus32.result); end
        nCompared++; if (bus32.out_valid !== 1'b1) begin nFailed++; $display("[TB] FAIL b2b_out_valid: got %b expected 1", bus32.out_valid); end
        nCompared++; if (readyOk !== 1'b1) begin nFailed++; $display("[TB] FAIL b2b_in_ready: got %b expected 1", readyOk); end
    endtask

    task automatic test_multi_cycle();
        int cycles;
        bit busyOk;
        run_multi(5'd16, 32'h10000, 32'h10000, cycles, busyOk);
        nCompared++; if (cycles !== 32) begin nFailed++; $display("[TB] FAIL mul_latency: got %0d expected 32", cycles); end
        nCompared++; if (busyOk !== 1'b1) begin nFailed++; $display("[TB] FAIL mul_busy_window: got %b expected 1", busyOk); end
        nCompared++; if (bus32.result !== 32'h0) begin nFailed++; $display("[TB] FAIL mul_result: got %h expected 0", bus32.result); end
        nCompared++; if ({bus32.carry_out, bus32.zero, bus32.overflow, bus32.busy} !== 4'b1100)
            begin nFailed++; $display("[TB] FAIL mul_flags(c,z,ovf,busy): got %b expected 1100", {bus32.carry_out, bus32.zero, bus32.overflow, bus32.busy}); end
        run_multi(5'd17, 32'h10000, 32'h10000, cycles, busyOk);
        nCompared++; if (bus32.result !== 32'h1) begin nFailed++; $display("[TB] FAIL mulhu_result: got %h expected 1", bus32.result); end
        nCompared++; if (bus32.carry_out !== 1'b1) begin nFailed++; $display("[TB] FAIL mulhu_carry: got %b expected 1", bus32.carry_out); end
        run_multi(5'd16, 32'h1234, 32'h100, cycles, busyOk);
        nCompared++; if (bus32.result !== 32'h123400) begin nFailed++; $display("[TB] FAIL mul_small: got %h expected 123400", bus32.result); end
        nCompared++; if (bus32.carry_out !== 1'b0) begin nFailed++; $display("[TB] FAIL mul_small_carry: got %b expected 0", bus32.carry_out); end
        run_multi(5'd18, 32'd100, 32'd7, cycles, busyOk);
        nCompared++; if (cycles !== 32) begin nFailed++; $display("[TB] FAIL divu_latency: got %0d expected 32", cycles); end
        nCompared++; if (bus32.result !== 32'd14) begin nFailed++; $display("[TB] FAIL divu_result: got %h expected e", bus32.result); end
        run_multi(5'd19, 32'd100, 32'd7, cycles, busyOk);
        nCompared++; if (bus32.result !== 32'd2) begin nFailed++; $display("[TB] FAIL remu_result: got %h expected 2", bus32.result); end
        run_multi(5'd18, 32'h1234, 32'h0, cycles, busyOk);
        nCompared++; if (cycles !== 32) begin nFailed++; $display("[TB] FAIL divz_latency: got %0d expected 32", cycles); end
        nCompared++; if (bus32.result !== 32'hFFFFFFFF) begin nFailed++; $display("[TB] FAIL divz_result: got %h expected ffffffff", bus32.result); end
        nCompared++; if ({bus32.overflow, bus32.carry_out} !== 2'b10)
            begin nFailed++; $display("[TB] FAIL divz_flags(ovf,c): got %b expected 10", {bus32.overflow, bus32.carry_out}); end
        run_multi(5'd19, 32'h1234, 32'h0, cycles, busyOk);
        nCompared++; if (bus32.result !== 32'h1234) begin nFailed++; $display("[TB] FAIL remz_result: got %h expected 1234", bus32.result); end
        nCompared++; if (bus32.overflow !== 1'b1) begin nFailed++; $display("[TB] FAIL remz_overflow: got %b expected 1", bus32.overflow); end
    endtask

    task automatic test_backpressure();
        bit holdOk = 1'b1;
        @(negedge clk);
        drive(5'd0, 32'd5, 32'd3);
        @(negedge clk);
        bus32.out_ready = 1'b0;
        drive(5'd1, 32'd10, 32'd4);
        for (int i = 0; i < 5; i++) begin
            #1;
            if (!(bus32.in_ready === 1'b0 && bus32.out_valid === 1'b1 && bus32.result === 32'd8 &&
                  bus32.zero === 1'b0 && bus32.carry_out === 1'b0)) holdOk = 1'b0;
            @(negedge clk);
        end
        nCompared++; if (holdOk !== 1'b1) begin nFailed++; $display("[TB] FAIL bp_hold: got %b expected 1", holdOk); end
        bus32.out_ready = 1'b1;
        #1;
        nCompared++; if (bus32.in_ready !== 1'b1) begin nFailed++; $display("[TB] FAIL bp_release_ready: got %b expected 1", bus32.in_ready); end
        @(negedge clk);
        bus32.in_valid = 1'b0;
        nCompared++; if (bus32.result !== 32'd6) begin nFailed++; $display("[TB] FAIL bp_next_result: got %h expected 6", bus32.result); end
        nCompared++; if (bus32.out_valid !== 1'b1) begin nFailed++; $display("[TB] FAIL bp_next_valid: got %b expected 1", bus32.out_valid); end
        @(negedge clk);
        nCompared++; if (bus32.out_valid !== 1'b0) begin nFailed++; $display("[TB] FAIL bp_drop_valid: got %b expected 0", bus32.out_valid); end
    endtask

    task automatic test_reset_mid_calc();
        bit quietOk = 1'b1;
        drive(5'd16, 32'd3, 32'd5);
        @(negedge clk);
        bus32.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        nCompared++; if (bus32.busy !== 1'b1) begin nFailed++; $display("[TB] FAIL rst_mid_busy_before: got %b expected 1", bus32.busy); end
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        nCompared++; if ({bus32.out_valid, bus32.busy, bus32.in_ready} !== 3'b000)
            begin nFailed++; $display("[TB] FAIL rst_mid_ctrl(valid,busy,ready): got %b expected 000", {bus32.out_valid, bus32.busy, bus32.in_ready}); end
        nCompared++; if (bus32.result !== 32'h0) begin nFailed++; $display("[TB] FAIL rst_mid_result: got %h expected 0", bus32.result); end
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus32.out_valid !== 1'b0) quietOk = 1'b0;
        end
        nCompared++; if (quietOk !== 1'b1) begin nFailed++; $display("[TB] FAIL rst_mid_discard: got %b expected 1", quietOk); end
        drive(5'd0, 32'd2, 32'd3);
        @(negedge clk);
        bus32.in_valid = 1'b0;
        nCompared++; if (bus32.result !== 32'd5) begin nFailed++; $display("[TB] FAIL rst_mid_add: got %h expected 5", bus32.result); end
    endtask

    task automatic test_illegal();
        drive(5'd25, 32'd5, 32'd6);
        @(negedge clk);
        bus32.in_valid = 1'b0;
        nCompared++; if (bus32.result !== 32'h0) begin nFailed++; $display("[TB] FAIL illegal_result: got %h expected 0", bus32.result); end
        nCompared++; if ({bus32.illegal_op, bus32.zero, bus32.negative, bus32.carry_out, bus32.overflow} !== 5'b11000)
            begin nFailed++; $display("[TB] FAIL illegal_flags(ill,z,n,c,ovf): got %b expected 11000", {bus32.illegal_op, bus32.zero, bus32.negative, bus32.carry_out, bus32.overflow}); end
        drive(5'd15, 32'h80000001, 32'd0);
        @(negedge clk);
        bus32.in_valid = 1'b0;
        nCompared++; if (bus32.result !== 32'h80000001) begin nFailed++; $display("[TB] FAIL pass_result: got %h expected 80000001", bus32.result); end
        nCompared++; if ({bus32.illegal_op, bus32.negative} !== 2'b01)
            begin nFailed++; $display("[TB] FAIL pass_flags(ill,neg): got %b expected 01", {bus32.illegal_op, bus32.negative}); end
    endtask

    task automatic test_width8();
        int cycles = 0;
        bus8.in_valid = 1'b1;
        bus8.opcode   = 5'd16;
        bus8.a        = 8'h10;
        bus8.b        = 8'h10;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        bus8.a        = 8'hFF;
        while (bus8.out_valid !== 1'b1 && cycles < 50) begin
            @(negedge clk);
            cycles++;
        end
        nCompared++; if (cycles !== 8) begin nFailed++; $display("[TB] FAIL w8_latency: got %0d expected 8", cycles); end
        nCompared++; if (bus8.result !== 8'h00) begin nFailed++; $display("[TB] FAIL w8_mul_result: got %h expected 00", bus8.result); end
        nCompared++; if ({bus8.carry_out, bus8.zero} !== 2'b11)
            begin nFailed++; $display("[TB] FAIL w8_mul_flags(c,z): got %b expected 11", {bus8.carry_out, bus8.zero}); end
    endtask

    // Global time limit so a stuck handshake can never hang the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Run every scenario in order and print the summary.
    initial begin
        rst_n           = 1'b0;
        bus32.in_valid  = 1'b0;
        bus32.a         = '0;
        bus32.b         = '0;
        bus32.opcode    = '0;
        bus32.out_ready = 1'b1;
        bus8.in_valid   = 1'b0;
        bus8.a          = '0;
        bus8.b          = '0;
        bus8.opcode     = '0;
        bus8.out_ready  = 1'b1;
        test_reset();
        test_add_sub();
        test_shift_cmp();
        test_back_to_back();
        test_multi_cycle();
        test_backpressure();
        test_reset_mid_calc();
        test_illegal();
        test_width8();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end
endmodule
